rob_param_commit: RTL and testbench

// - Parametrised reorder buffer for the out-of-order RV32I core.
// - Allocates entries in program order from issue, captures results from NUM_CDB broadcast buses and the store unit, and retires one entry per clock in order.
// - Retirement drives the register file, the register status table, data memory writes and PC redirect.
// - Adds over the previous ROB: a synchronous clocked design, configurable depth and CDB count, an issue handshake, and a full flush on branch mispredict.

---
 rtl/rob_param_commit.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_rob_param_commit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_param_commit.sv
`default_nettype none
// ============================================================================
//  Module      : rob_param_commit
//  Description : Parametrised reorder buffer for the out-of-order RV32I core.
//                Allocates in program order, captures results from NUM_CDB
//                broadcast buses and the store unit, retires one entry per
//                clock in order, and flushes on a retiring mispredict.
//                Optional feature macro: ROB_CDB_BYPASS_EN (same-cycle CDB
//                forwarding into the qa/qb operand lookups).
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_param_commit #(
  parameter int DEPTH   = 16,
  parameter int TAG_W   = 4,
  parameter int NUM_CDB = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // issue
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic [2:0]                 issue_kind_i,
  input  logic [4:0]                 issue_dest_i,
  input  logic [2:0]                 issue_subop_i,
  output logic [TAG_W-1:0]           issue_tag_o,
  // common data buses
  input  logic [NUM_CDB-1:0]         cdb_valid_i,
  input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag_i,
  input  logic [NUM_CDB*32-1:0]      cdb_data_i,
  input  logic [NUM_CDB-1:0]         cdb_mispred_i,
  // store unit
  input  logic                       st_valid_i,
  input  logic [TAG_W-1:0]           st_tag_i,
  input  logic [31:0]                st_addr_i,
  input  logic [31:0]                st_data_i,
  // operand lookups
  input  logic [TAG_W-1:0]           qa_tag_i,
  input  logic [TAG_W-1:0]           qb_tag_i,
  output logic                       qa_rdy_o,
  output logic                       qb_rdy_o,
  output logic [31:0]                qa_data_o,
  output logic [31:0]                qb_data_o,
  // register file / status table commit
  output logic                       reg_we_o,
  output logic [4:0]                 reg_waddr_o,
  output logic [31:0]                reg_wdata_o,
  output logic [TAG_W-1:0]           reg_wtag_o,
  // store commit
  output logic                       mem_we_o,
  output logic [31:0]                mem_addr_o,
  output logic [31:0]                mem_data_o,
  output logic [2:0]                 mem_size_o,
  // control
  output logic                       redirect_valid_o,
  output logic [31:0]                redirect_pc_o,
  output logic                       flush_o,
  output logic                       halt_o,
  output logic [TAG_W:0]             count_o
);

  localparam logic [2:0] c_KIND_ALU    = 3'd0;
  localparam logic [2:0] c_KIND_LOAD   = 3'd1;
  localparam logic [2:0] c_KIND_STORE  = 3'd2;
  localparam logic [2:0] c_KIND_BRANCH = 3'd3;
  localparam logic [2:0] c_KIND_JUMP   = 3'd4;
  localparam logic [2:0] c_KIND_HALT   = 3'd5;

  // entry storage
  logic              valid_q   [DEPTH];
  logic              ready_q   [DEPTH];
  logic              mispred_q [DEPTH];
  logic [2:0]        kind_q    [DEPTH];
  logic [4:0]        dest_q    [DEPTH];
  logic [2:0]        subop_q   [DEPTH];
  logic [31:0]       data_q    [DEPTH];
  logic [31:0]       addr_q    [DEPTH];

  // pointers carry one extra wrap bit
  logic [TAG_W:0]    head_q, head_d;
  logic [TAG_W:0]    tail_q, tail_d;
  logic              halt_q, halt_d;
  logic              flush_q, flush_d;
  logic              redirect_q, redirect_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic              reg_we_q, reg_we_d;
  logic [4:0]        reg_waddr_q, reg_waddr_d;
  logic [31:0]       reg_wdata_q, reg_wdata_d;
  logic [TAG_W-1:0]  reg_wtag_q, reg_wtag_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic [2:0]        mem_size_q, mem_size_d;

  logic [TAG_W-1:0]  w_cdb_tag  [NUM_CDB];
  logic [31:0]       w_cdb_data [NUM_CDB];

  logic [TAG_W-1:0]  w_head_idx, w_tail_idx;
  logic              w_empty, w_full;
  logic              w_issue_fire, w_retire, w_mispred_retire;
  logic [2:0]        w_head_kind;

  // Split the flattened CDB buses into per-channel views
  for (genvar g = 0; g < NUM_CDB; g++) begin : g_cdb_unpack
    assign w_cdb_tag[g]  = cdb_tag_i[g*TAG_W +: TAG_W];
    assign w_cdb_data[g] = cdb_data_i[g*32 +: 32];
  end

  assign w_head_idx   = head_q[TAG_W-1:0];
  assign w_tail_idx   = tail_q[TAG_W-1:0];
  assign w_empty      = (head_q == tail_q);
  assign w_full       = (w_head_idx == w_tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
  assign w_head_kind  = kind_q[w_head_idx];

  assign issue_ready_o = !w_full && !flush_q && !halt_q;
  assign issue_tag_o   = w_tail_idx;
  assign w_issue_fire  = issue_valid_i && issue_ready_o;
  assign w_retire      = !w_empty && ready_q[w_head_idx] && !halt_q && !flush_q;
  assign w_mispred_retire = w_retire && mispred_q[w_head_idx] &&
                            ((w_head_kind == c_KIND_BRANCH) || (w_head_kind == c_KIND_JUMP));

  assign count_o = tail_q - head_q;

  // Next pointer, halt and one-cycle commit pulse computation
  always_comb begin
    head_d        = head_q + {{TAG_W{1'b0}}, w_retire};
    tail_d        = tail_q + {{TAG_W{1'b0}}, w_issue_fire};
    halt_d        = halt_q | (w_retire && (w_head_kind == c_KIND_HALT));
    flush_d       = w_mispred_retire;
    redirect_d    = w_mispred_retire;
    redirect_pc_d = w_mispred_retire ? data_q[w_head_idx] : 32'd0;
    reg_we_d      = 1'b0;
    reg_waddr_d   = 5'd0;
    reg_wdata_d   = 32'd0;
    reg_wtag_d    = '0;
    mem_we_d      = 1'b0;
    mem_addr_d    = 32'd0;
    mem_data_d    = 32'd0;
    mem_size_d    = 3'd0;
    if (w_retire) begin
      case (w_head_kind)
        // A JUMP's CDB word is both its link value and its redirect target
        c_KIND_ALU, c_KIND_LOAD, c_KIND_JUMP: begin
          reg_we_d    = (dest_q[w_head_idx] != 5'd0);
          reg_waddr_d = dest_q[w_head_idx];
          reg_wdata_d = data_q[w_head_idx];
          reg_wtag_d  = w_head_idx;
        end
        c_KIND_STORE: begin
          mem_we_d   = 1'b1;
          mem_addr_d = addr_q[w_head_idx];
          mem_data_d = data_q[w_head_idx];
          mem_size_d = subop_q[w_head_idx];
        end
        default: ;
      endcase
    end
    if (w_mispred_retire) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  // Pointer, status and registered commit outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q        <= '0;
      tail_q        <= '0;
      halt_q        <= 1'b0;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      reg_we_q      <= 1'b0;
      reg_waddr_q   <= 5'd0;
      reg_wdata_q   <= 32'd0;
      reg_wtag_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_data_q    <= 32'd0;
      mem_size_q    <= 3'd0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      halt_q        <= halt_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      reg_we_q      <= reg_we_d;
      reg_waddr_q   <= reg_waddr_d;
      reg_wdata_q   <= reg_wdata_d;
      reg_wtag_q    <= reg_wtag_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      mem_size_q    <= mem_size_d;
    end
  end

  // Entry updates: result capture, allocation, retire clear, mispredict kill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]   <= 1'b0;
        ready_q[i]   <= 1'b0;
        mispred_q[i] <= 1'b0;
        kind_q[i]    <= 3'd0;
        dest_q[i]    <= 5'd0;
        subop_q[i]   <= 3'd0;
        data_q[i]    <= 32'd0;
        addr_q[i]    <= 32'd0;
      end
    end else if (w_mispred_retire) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]   <= 1'b0;
        ready_q[i]   <= 1'b0;
        mispred_q[i] <= 1'b0;
      end
    end else begin
      // Results arriving during the flush cycle belong to killed work
      if (!flush_q) begin
        // later channels overwrite earlier ones: highest index wins
        for (int i = 0; i < NUM_CDB; i++) begin
          if (cdb_valid_i[i] && valid_q[w_cdb_tag[i]]) begin
            ready_q[w_cdb_tag[i]]   <= 1'b1;
            data_q[w_cdb_tag[i]]    <= w_cdb_data[i];
            mispred_q[w_cdb_tag[i]] <= cdb_mispred_i[i];
          end
        end
        if (st_valid_i && valid_q[st_tag_i]) begin
          ready_q[st_tag_i] <= 1'b1;
          addr_q[st_tag_i]  <= st_addr_i;
          data_q[st_tag_i]  <= st_data_i;
        end
      end
      if (w_issue_fire) begin
        valid_q[w_tail_idx]   <= 1'b1;
        ready_q[w_tail_idx]   <= (issue_kind_i == c_KIND_HALT);
        mispred_q[w_tail_idx] <= 1'b0;
        kind_q[w_tail_idx]    <= issue_kind_i;
        dest_q[w_tail_idx]    <= issue_dest_i;
        subop_q[w_tail_idx]   <= issue_subop_i;
      end
      if (w_retire) begin
        valid_q[w_head_idx] <= 1'b0;
        ready_q[w_head_idx] <= 1'b0;
      end
    end
  end

  // Operand lookups read stored state, optionally forwarding live CDB results
  always_comb begin
    qa_rdy_o  = valid_q[qa_tag_i] && ready_q[qa_tag_i];
    qa_data_o = data_q[qa_tag_i];
    qb_rdy_o  = valid_q[qb_tag_i] && ready_q[qb_tag_i];
    qb_data_o = data_q[qb_tag_i];
`ifdef ROB_CDB_BYPASS_EN
    for (int i = 0; i < NUM_CDB; i++) begin
      if (cdb_valid_i[i] && !flush_q) begin
        if ((w_cdb_tag[i] == qa_tag_i) && valid_q[qa_tag_i]) begin
          qa_rdy_o  = 1'b1;
          qa_data_o = w_cdb_data[i];
        end
        if ((w_cdb_tag[i] == qb_tag_i) && valid_q[qb_tag_i]) begin
          qb_rdy_o  = 1'b1;
          qb_data_o = w_cdb_data[i];
        end
      end
    end
`else
    // without forwarding a CDB value becomes visible the cycle after capture
`endif
  end

  assign reg_we_o         = reg_we_q;
  assign reg_waddr_o      = reg_waddr_q;
  assign reg_wdata_o      = reg_wdata_q;
  assign reg_wtag_o       = reg_wtag_q;
  assign mem_we_o         = mem_we_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_data_o       = mem_data_q;
  assign mem_size_o       = mem_size_q;
  assign redirect_valid_o = redirect_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign flush_o          = flush_q;
  assign halt_o           = halt_q;

endmodule
`default_nettype wire

// File: tb/tb_rob_param_commit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_param_commit
//  Description : Directed self-checking bench for rob_param_commit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_param_commit;

  localparam int TAG_W   = 4;
  localparam int NUM_CDB = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     issue_valid;
  logic                     issue_ready;
  logic [2:0]               issue_kind;
  logic [4:0]               issue_dest;
  logic [2:0]               issue_subop;
  logic [TAG_W-1:0]         issue_tag;
  logic [NUM_CDB-1:0]       cdb_valid;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag;
  logic [NUM_CDB*32-1:0]    cdb_data;
  logic [NUM_CDB-1:0]       cdb_mispred;
  logic                     st_valid;
  logic [TAG_W-1:0]         st_tag;
  logic [31:0]              st_addr, st_data;
  logic [TAG_W-1:0]         qa_tag, qb_tag;
  logic                     qa_rdy, qb_rdy;
  logic [31:0]              qa_data, qb_data;
  logic                     reg_we;
  logic [4:0]               reg_waddr;
  logic [31:0]              reg_wdata;
  logic [TAG_W-1:0]         reg_wtag;
  logic                     mem_we;
  logic [31:0]              mem_addr, mem_data;
  logic [2:0]               mem_size;
  logic                     redirect_valid;
  logic [31:0]              redirect_pc;
  logic                     flush, halt;
  logic [TAG_W:0]           count;

  int n_checks = 0;
  int n_errors = 0;

  rob_param_commit #(.DEPTH(16), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_kind_i(issue_kind), .issue_dest_i(issue_dest),
    .issue_subop_i(issue_subop), .issue_tag_o(issue_tag),
    .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
    .cdb_data_i(cdb_data), .cdb_mispred_i(cdb_mispred),
    .st_valid_i(st_valid), .st_tag_i(st_tag),
    .st_addr_i(st_addr), .st_data_i(st_data),
    .qa_tag_i(qa_tag), .qb_tag_i(qb_tag),
    .qa_rdy_o(qa_rdy), .qb_rdy_o(qb_rdy),
    .qa_data_o(qa_data), .qb_data_o(qb_data),
    .reg_we_o(reg_we), .reg_waddr_o(reg_waddr),
    .reg_wdata_o(reg_wdata), .reg_wtag_o(reg_wtag),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .mem_size_o(mem_size),
    .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
    .flush_o(flush), .halt_o(halt), .count_o(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_kind = 3'd0; issue_dest = 5'd0; issue_subop = 3'd0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0; cdb_mispred = '0;
    st_valid = 1'b0; st_tag = '0; st_addr = 32'd0; st_data = 32'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [2:0] kind, input logic [4:0] dest, input logic [2:0] subop);
    issue_valid = 1'b1; issue_kind = kind; issue_dest = dest; issue_subop = subop;
    tick();
    issue_valid = 1'b0;
  endtask

  // drive one CDB channel for the coming edge
  task automatic cdb_set(input int ch, input logic [TAG_W-1:0] t, input logic [31:0] d, input logic mp);
    cdb_valid[ch]                = 1'b1;
    cdb_tag[ch*TAG_W +: TAG_W]   = t;
    cdb_data[ch*32 +: 32]        = d;
    cdb_mispred[ch]              = mp;
  endtask

  initial begin
    qa_tag = '0; qb_tag = '0;
    do_reset();
    tick();

    // ---- reset state
    check("rst_issue_ready", issue_ready, 1);
    check("rst_count", count, 0);
    check("rst_issue_tag", issue_tag, 0);
    check("rst_outputs", {reg_we, mem_we, redirect_valid, flush, halt, qa_rdy}, 0);

    // ---- fill to capacity
    for (int i = 0; i < 16; i++) issue(3'd0, 5'(i + 1), 3'd0);
    check("full_count", count, 16);
    check("full_ready", issue_ready, 0);
    check("full_tag_wrap", issue_tag, 0);
    issue(3'd0, 5'd20, 3'd0);
    check("full_17th_rejected", count, 16);

    cdb_set(0, 4'd0, 32'h100, 1'b0);
    tick(); idle();
    check("full_no_early_retire", reg_we, 0);
    tick();
    check("retire0_we", reg_we, 1);
    check("retire0_waddr", reg_waddr, 1);
    check("retire0_wdata", reg_wdata, 32'h100);
    check("retire0_count", count, 15);
    check("retire0_ready", issue_ready, 1);

    cdb_set(0, 4'd1, 32'h111, 1'b0);
    tick(); idle();
    // retire of tag 1 and allocation into wrapped slot 0 on the same edge
    issue(3'd0, 5'd9, 3'd0);
    check("same_edge_count", count, 15);
    check("same_edge_wtag", reg_wtag, 1);
    check("same_edge_wdata", reg_wdata, 32'h111);
    check("same_edge_tail", issue_tag, 1);

    // ---- asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_ready", issue_ready, 1);
    rst_n = 1'b1;
    tick();

    // ---- out-of-order completion, in-order retire, CDB priority, x0
    issue(3'd0, 5'd5, 3'd0);
    issue(3'd1, 5'd6, 3'd0);
    issue(3'd0, 5'd0, 3'd0);
    issue(3'd0, 5'd8, 3'd0);
    cdb_set(0, 4'd3, 32'h33, 1'b0);
    tick(); idle();
    check("ooo_wait3", reg_we, 0);
    cdb_set(0, 4'd2, 32'h22, 1'b0);
    tick(); idle();
    check("ooo_wait2", reg_we, 0);
    qa_tag = 4'd1; qb_tag = 4'd3;
    cdb_set(0, 4'd1, 32'hA, 1'b0);
    cdb_set(1, 4'd1, 32'hB, 1'b0);
    #1;
`ifdef ROB_CDB_BYPASS_EN
    check("bypass_rdy", qa_rdy, 1);
    check("bypass_data", qa_data, 32'hB);
`else
    check("nobypass_rdy", qa_rdy, 0);
`endif
    check("qb_stored_rdy", qb_rdy, 1);
    check("qb_stored_data", qb_data, 32'h33);
    tick(); idle();
    check("qa_next_rdy", qa_rdy, 1);
    check("qa_next_data", qa_data, 32'hB);
    check("ooo_wait1", reg_we, 0);
    cdb_set(0, 4'd0, 32'h44, 1'b0);
    tick(); idle();
    check("ooo_wait0", reg_we, 0);
    tick();
    check("ooo_r0", {reg_we, reg_waddr, reg_wdata, reg_wtag}, {1'b1, 5'd5, 32'h44, 4'd0});
    tick();
    check("ooo_r1_prio", {reg_we, reg_waddr, reg_wdata, reg_wtag}, {1'b1, 5'd6, 32'hB, 4'd1});
    tick();
    check("ooo_r2_x0", reg_we, 0);
    check("ooo_r2_count", count, 1);
    tick();
    check("ooo_r3", {reg_we, reg_waddr, reg_wdata, reg_wtag}, {1'b1, 5'd8, 32'h33, 4'd3});
    check("ooo_empty", count, 0);

    // ---- branch mispredict flush
    do_reset();
    issue(3'd0, 5'd1, 3'd0);
    issue(3'd0, 5'd2, 3'd0);
    issue(3'd3, 5'd0, 3'd0);
    issue(3'd0, 5'd4, 3'd0);
    cdb_set(0, 4'd0, 32'h10, 1'b0);
    cdb_set(1, 4'd1, 32'h20, 1'b0);
    tick(); idle();
    cdb_set(0, 4'd2, 32'h100, 1'b1);
    cdb_set(1, 4'd3, 32'h40, 1'b0);
    tick(); idle();
    check("br_r0", reg_wtag, 0);
    tick();
    check("br_r1", reg_wtag, 1);
    tick();
    check("br_redirect", redirect_valid, 1);
    check("br_pc", redirect_pc, 32'h100);
    check("br_flush", flush, 1);
    check("br_count", count, 0);
    check("br_issue_tag", issue_tag, 0);
    check("br_ready_low", issue_ready, 0);
    check("br_no_regwrite", reg_we, 0);
    issue_valid = 1'b1;
    cdb_set(0, 4'd0, 32'h55, 1'b0);
    tick(); idle();
    check("br_flush_pulse", {flush, redirect_valid}, 0);
    check("br_discard_issue", count, 0);
    check("br_after_tag", issue_tag, 0);
    check("br_after_ready", issue_ready, 1);

    // ---- store commit
    do_reset();
    issue(3'd2, 5'd0, 3'd2);
    st_valid = 1'b1; st_tag = 4'd0; st_addr = 32'h200; st_data = 32'hDEAD;
    tick(); idle();
    check("st_wait", mem_we, 0);
    tick();
    check("st_commit", {mem_we, mem_addr, mem_data, mem_size}, {1'b1, 32'h200, 32'hDEAD, 3'd2});
    check("st_no_reg", reg_we, 0);

    // ---- halt
    issue(3'd5, 5'd0, 3'd0);
    check("halt_pending", halt, 0);
    tick();
    check("halt_set", halt, 1);
    check("halt_ready", issue_ready, 0);
    issue(3'd0, 5'd3, 3'd0);
    check("halt_no_issue", count, 0);
    tick();
    check("halt_sticky", halt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
